// File: rtl/digit_tx_pkg.sv
// -----------------------------------------------------------------------------
// digit_tx_pkg
// Shared definitions for the digital-level link transmitter:
//   - tx_state_t : frame FSM states (IDLE, PREAMBLE, DATA, PARITY, GAP)
//   - DEF_HIGH_LVL / DEF_LOW_LVL : default DAC codes for '1' and '0'/idle
//   - BIT_CNT_W  : width of the bit-period counter (BIT_CLKS up to 2^24-1)
// -----------------------------------------------------------------------------
package digit_tx_pkg;

  localparam int BIT_CNT_W = 24;

  localparam logic [7:0] DEF_HIGH_LVL = 8'd200;
  localparam logic [7:0] DEF_LOW_LVL  = 8'd50;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_t;

endpackage

// File: rtl/digit_bit_timer.sv
// -----------------------------------------------------------------------------
// digit_bit_timer
// Bit-period counter: counts 0..BIT_CLKS-1 while enabled and pulses bit_tick
// in the last cycle of each bit period, wrapping to 0 on that edge.
// Ports:
//   clk      in  system clock (rising edge)
//   rst_n    in  asynchronous active-low reset
//   en       in  count enable
//   clr      in  synchronous clear (takes priority over en)
//   bit_tick out high during the final cycle of a bit period
// -----------------------------------------------------------------------------
module digit_bit_timer
  import digit_tx_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(BIT_CLKS - 1);

  logic [BIT_CNT_W-1:0] cnt_q;

  assign bit_tick = en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/digit_tx_modulator.sv
// -----------------------------------------------------------------------------
// digit_tx_modulator
// Transmit end of the digital-level link. Serializes bytes into an 8-bit DAC
// amplitude stream (HIGH_LVL for '1', LOW_LVL for '0'/idle) framed as
//   preamble (1,0,1,0,...) | 8 data bits MSB first | [even parity] | gap (LOW)
// and produces the 'sys' strobe that toggles at every bit boundary.
// Optional feature macro: DIGIT_TX_PARITY_EN adds one even-parity bit after
// the data bits.
// Ports:
//   clk       in   system clock (rising edge)
//   rst_n     in   asynchronous active-low reset
//   din[7:0]  in   byte to transmit
//   din_valid in   din valid
//   din_ready out  holding register empty; transfer on din_valid & din_ready
//   dac_out   out  registered DAC amplitude code
//   sys       out  registered bit-phase strobe
//   bit_out   out  registered bit currently on the line
//   busy      out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module digit_tx_modulator
  import digit_tx_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 500,
  parameter logic [7:0]  HIGH_LVL = DEF_HIGH_LVL,
  parameter logic [7:0]  LOW_LVL  = DEF_LOW_LVL,
  parameter int unsigned PRE_BITS = 8,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dac_out,
  output logic       sys,
  output logic       bit_out,
  output logic       busy
);

  if (HIGH_LVL <= LOW_LVL) begin : g_lvl_chk
    $error("digit_tx_modulator: HIGH_LVL must exceed LOW_LVL");
  end
  if (BIT_CLKS < 2 || BIT_CLKS > 32'h00FF_FFFF) begin : g_clks_chk
    $error("digit_tx_modulator: BIT_CLKS out of range 2..2^24-1");
  end
  if (PRE_BITS < 2 || PRE_BITS > 255 || GAP_BITS > 255) begin : g_bits_chk
    $error("digit_tx_modulator: PRE_BITS or GAP_BITS out of range");
  end

  localparam logic [7:0] PRE_LAST = 8'(PRE_BITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);
  localparam bit         GAP_EN   = (GAP_BITS != 0);

  tx_state_t  state_q, state_nxt;
  logic [7:0] idx_q, idx_nxt;
  logic       bit_q, bit_nxt;
  logic       sys_q, busy_q;
  logic [7:0] dac_q;
  logic       hold_full_q;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic       bit_tick;
  logic       accept;
  logic       load, shift_en, toggle;
  logic       start, payload_done, gap_done;
`ifdef DIGIT_TX_PARITY_EN
  logic       parity_q;
`endif

  assign din_ready = !hold_full_q;
  assign accept    = din_valid && !hold_full_q;

  assign dac_out = dac_q;
  assign sys     = sys_q;
  assign bit_out = bit_q;
  assign busy    = busy_q;

  digit_bit_timer #(
    .BIT_CLKS (BIT_CLKS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != ST_IDLE),
    .clr      (state_q == ST_IDLE),
    .bit_tick (bit_tick)
  );

  // Next-state / next-bit decode. The value chosen for bit_nxt is what appears
  // on the line after this edge, so all outputs change together at a boundary.
  always_comb begin
    state_nxt    = state_q;
    idx_nxt      = idx_q;
    bit_nxt      = bit_q;
    load         = 1'b0;
    shift_en     = 1'b0;
    toggle       = 1'b0;
    start        = 1'b0;
    payload_done = 1'b0;
    gap_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) start = 1'b1;
      end
      ST_PREAMBLE: begin
        if (bit_tick) begin
          toggle = 1'b1;
          if (idx_q == PRE_LAST) begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
            bit_nxt   = shift_q[7];
          end else begin
            // next index is idx+1; even indices carry '1'
            idx_nxt = idx_q + 8'd1;
            bit_nxt = idx_q[0];
          end
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          toggle = 1'b1;
          if (idx_q == 8'd7) begin
`ifdef DIGIT_TX_PARITY_EN
            state_nxt = ST_PARITY;
            idx_nxt   = '0;
            bit_nxt   = parity_q;
`else
            payload_done = 1'b1;
`endif
          end else begin
            idx_nxt  = idx_q + 8'd1;
            shift_en = 1'b1;
            bit_nxt  = shift_q[6];
          end
        end
      end
`ifdef DIGIT_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          toggle       = 1'b1;
          payload_done = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        if (bit_tick) begin
          toggle = 1'b1;
          if (idx_q == GAP_LAST) gap_done = 1'b1;
          else                   idx_nxt  = idx_q + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        bit_nxt   = 1'b0;
      end
    endcase

    if (payload_done) begin
      if (GAP_EN) begin
        state_nxt = ST_GAP;
        idx_nxt   = '0;
        bit_nxt   = 1'b0;
      end else begin
        gap_done = 1'b1;
      end
    end

    // End of frame: chain straight into the next preamble if a byte waits,
    // otherwise drop to IDLE without a sys toggle.
    if (gap_done) begin
      if (hold_full_q) begin
        start = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        bit_nxt   = 1'b0;
        toggle    = 1'b0;
      end
    end

    if (start) begin
      state_nxt = ST_PREAMBLE;
      idx_nxt   = '0;
      bit_nxt   = 1'b1;
      load      = 1'b1;
      toggle    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bit_q       <= 1'b0;
      sys_q       <= 1'b0;
      busy_q      <= 1'b0;
      dac_q       <= LOW_LVL;
      hold_full_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      bit_q   <= bit_nxt;
      sys_q   <= sys_q ^ toggle;
      busy_q  <= (state_nxt != ST_IDLE);
      dac_q   <= bit_nxt ? HIGH_LVL : LOW_LVL;
      // load only happens while full, so it can never coincide with accept
      if (load)        hold_full_q <= 1'b0;
      else if (accept) hold_full_q <= 1'b1;
    end
  end

  // Data registers carry no reset; their contents are qualified by
  // hold_full_q and the FSM state.
  always_ff @(posedge clk) begin
    if (accept) hold_q <= din;
    if (load)          shift_q <= hold_q;
    else if (shift_en) shift_q <= {shift_q[6:0], 1'b0};
  end

`ifdef DIGIT_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (load) parity_q <= ^hold_q;
  end
`endif

endmodule
